// File: rtl/mem_ab_if.sv
// Operand memory bus for the systolic array feeder.
// Row writes for A, row loads for B, skewed A/B streams out.
interface mem_ab_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM)
);
  logic                      en;
  logic                      WrEn;
  logic [ROWBITS-1:0]        Arow;
  logic signed [BITS_AB-1:0] Ain  [DIM];
  logic signed [BITS_AB-1:0] Bin  [DIM];
  logic signed [BITS_AB-1:0] Aout [DIM];
  logic signed [BITS_AB-1:0] Bout [DIM];

  modport master (
    output en, WrEn, Arow, Ain, Bin,
    input  Aout, Bout
  );

  modport slave (
    input  en, WrEn, Arow, Ain, Bin,
    output Aout, Bout
  );
endinterface

// File: rtl/mem_ab.sv
// Combined A/B operand memory for an 8x8 systolic multiplier.
// Loads B row by row, then streams A and B with diagonal skew.
module mem_ab #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM)
) (
  input logic     clk,
  input logic     rst_n,
  mem_ab_if.slave bus
);
  localparam int KLAST = 3*DIM - 3;
  localparam int KBITS = $clog2(KLAST + 1);

  typedef logic signed [BITS_AB-1:0] elem_t;
  typedef enum logic {LOAD, STREAM} state_t;

  state_t             state_q, state_d;
  logic [ROWBITS-1:0] r_q, r_d;
  logic [KBITS-1:0]   k_q, k_d;

  elem_t a_q [DIM][DIM];
  elem_t a_d [DIM][DIM];
  elem_t b_q [DIM][DIM];
  elem_t b_d [DIM][DIM];
  elem_t aout_q [DIM];
  elem_t aout_d [DIM];
  elem_t bout_q [DIM];
  elem_t bout_d [DIM];

  logic [KBITS:0]     diff;
  logic [ROWBITS-1:0] idx;

  // A row write, independent of the sequencer; stream reads old a_q
  always_comb begin
    a_d = a_q;
    if (bus.WrEn) begin
      for (int c = 0; c < DIM; c++) begin
        a_d[bus.Arow][c] = bus.Ain[c];
      end
    end
  end

  // Sequencer next state, B load and skewed output selection
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    b_d     = b_q;
    aout_d  = aout_q;
    bout_d  = bout_q;
    diff    = '0;
    idx     = '0;
    if (bus.en) begin
      unique case (1'b1)
        (state_q == LOAD): begin
          for (int c = 0; c < DIM; c++) begin
            b_d[r_q][c] = bus.Bin[c];
            aout_d[c]   = '0;
            bout_d[c]   = '0;
          end
          if (r_q == ROWBITS'(DIM - 1)) begin
            state_d = STREAM;
            r_d     = '0;
            k_d     = '0;
          end else begin
            r_d = r_q + ROWBITS'(1);
          end
        end
        (state_q == STREAM): begin
          for (int j = 0; j < DIM; j++) begin
            diff = {1'b0, k_q} - (KBITS+1)'(j);
            idx  = diff[ROWBITS-1:0];
            if (!diff[KBITS] &&
                diff < (KBITS+1)'(DIM)) begin
              aout_d[j] = a_q[j][idx];
              bout_d[j] = b_q[idx][j];
            end else begin
              aout_d[j] = '0;
              bout_d[j] = '0;
            end
          end
          if (k_q == KBITS'(KLAST)) begin
            state_d = LOAD;
            r_d     = '0;
            k_d     = '0;
          end else begin
            k_d = k_q + KBITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All state and registered outputs, cleared by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      r_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < DIM; i++) begin
        aout_q[i] <= '0;
        bout_q[i] <= '0;
        for (int j = 0; j < DIM; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      for (int i = 0; i < DIM; i++) begin
        aout_q[i] <= aout_d[i];
        bout_q[i] <= bout_d[i];
        for (int j = 0; j < DIM; j++) begin
          a_q[i][j] <= a_d[i][j];
          b_q[i][j] <= b_d[i][j];
        end
      end
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_out
    assign bus.Aout[j] = aout_q[j];
    assign bus.Bout[j] = bout_q[j];
  end
endmodule

// File: tb/tb_mem_ab.sv
// Bench for mem_ab: directed scenarios plus random traffic,
// checked against a phase-based matrix model.
module tb_mem_ab;
  localparam int DIM  = 8;
  localparam int BITS = 8;
  localparam int NPH  = DIM + 3*DIM - 2;

  typedef logic signed [BITS-1:0] elem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ab_if #(.BITS_AB(BITS), .DIM(DIM)) bus ();

  mem_ab #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  elem_t ma [DIM][DIM];
  elem_t mb [DIM][DIM];
  elem_t ea [DIM];
  elem_t eb [DIM];
  elem_t ain_v [DIM];
  elem_t bin_v [DIM];
  elem_t sa [DIM];
  elem_t sb [DIM];
  int phase;
  int tests;
  int fails;

  task automatic check(string tag, elem_t obs, elem_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int j = 0; j < DIM; j++) begin
      check($sformatf("%s Aout%0d", tag, j), bus.Aout[j], ea[j]);
      check($sformatf("%s Bout%0d", tag, j), bus.Bout[j], eb[j]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIM; i++) begin
      ea[i] = '0;
      eb[i] = '0;
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
    end
    phase = 0;
  endtask

  // Called at a negedge; returns at the following negedge after checking
  task automatic step(bit en, bit wr, int arow, string tag);
    int k, d;
    bus.en   = en;
    bus.WrEn = wr;
    bus.Arow = 3'(arow);
    for (int c = 0; c < DIM; c++) begin
      bus.Ain[c] = ain_v[c];
      bus.Bin[c] = bin_v[c];
    end
    @(posedge clk);
    if (en) begin
      if (phase < DIM) begin
        for (int j = 0; j < DIM; j++) begin
          ea[j] = '0;
          eb[j] = '0;
          mb[phase][j] = bin_v[j];
        end
      end else begin
        k = phase - DIM;
        for (int j = 0; j < DIM; j++) begin
          d = k - j;
          if (d >= 0 && d < DIM) begin
            ea[j] = ma[j][d];
            eb[j] = mb[d][j];
          end else begin
            ea[j] = '0;
            eb[j] = '0;
          end
        end
      end
      phase = (phase + 1) % NPH;
    end
    if (wr) begin
      for (int c = 0; c < DIM; c++) ma[arow][c] = ain_v[c];
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < DIM; j++) begin
      check($sformatf("%s rstA%0d", tag, j), bus.Aout[j], elem_t'(0));
      check($sformatf("%s rstB%0d", tag, j), bus.Bout[j], elem_t'(0));
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_basic(bit pause, int abort_k);
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) bin_v[c] = elem_t'(8*i + c + 1);
      step(1'b1, 1'b0, 0, "bload");
    end
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) ain_v[c] = elem_t'(-(8*i + c + 1));
      step(1'b0, 1'b1, i, "awrite");
    end
    for (int c = 0; c < DIM; c++) bin_v[c] = elem_t'($urandom);
    for (int k = 0; k < 3*DIM - 2; k++) begin
      step(1'b1, 1'b0, 0, $sformatf("strm%0d", k));
      if (k == 0) begin
        check("e0 B0", bus.Bout[0], elem_t'(1));
        check("e0 A0", bus.Aout[0], elem_t'(-1));
      end
      if (k == 7) begin
        check("e7 B0", bus.Bout[0], elem_t'(57));
        check("e7 B7", bus.Bout[7], elem_t'(8));
        check("e7 A7", bus.Aout[7], elem_t'(-57));
        check("e7 A0", bus.Aout[0], elem_t'(-8));
      end
      if (k == 14) begin
        check("e14 B7", bus.Bout[7], elem_t'(64));
        check("e14 A7", bus.Aout[7], elem_t'(-64));
        check("e14 B0", bus.Bout[0], elem_t'(0));
      end
      if (k >= 15) begin
        check("drain A7", bus.Aout[7], elem_t'(0));
        check("drain B7", bus.Bout[7], elem_t'(0));
      end
      if (pause && k == 4) begin
        for (int j = 0; j < DIM; j++) begin
          sa[j] = ea[j];
          sb[j] = eb[j];
        end
        for (int p = 0; p < 3; p++) begin
          step(1'b0, 1'b0, 0, "pause");
          for (int j = 0; j < DIM; j++) begin
            check("hold A", bus.Aout[j], sa[j]);
            check("hold B", bus.Bout[j], sb[j]);
          end
        end
      end
      if (k == abort_k) begin
        do_reset("abort");
        return;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.en = 1'b0;
    bus.WrEn = 1'b0;
    bus.Arow = '0;
    for (int c = 0; c < DIM; c++) begin
      ain_v[c] = '0;
      bin_v[c] = '0;
      bus.Ain[c] = '0;
      bus.Bin[c] = '0;
    end
    model_reset();
    #12;
    check("por A0", bus.Aout[0], elem_t'(0));
    check("por B7", bus.Bout[7], elem_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // reset readback sweep
    for (int i = 0; i < DIM; i++) step(1'b0, 1'b0, i, "sweep");

    // basic stream, then one with a pause
    run_basic(1'b0, -1);
    run_basic(1'b1, -1);

    // extremes in A and B
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) begin
        bin_v[c] = (c % 2 == 0) ? elem_t'(-128) : elem_t'(127);
        ain_v[c] = bin_v[c];
      end
      step(1'b1, 1'b1, i, "xload");
    end
    for (int k = 0; k < 3*DIM - 2; k++) begin
      step(1'b1, 1'b0, 0, "xstrm");
      if (k == 0) check("x e0 A0", bus.Aout[0], elem_t'(-128));
      if (k == 8) check("x e8 B1", bus.Bout[1], elem_t'(127));
    end

    // reset mid-stream, then a clean rerun
    run_basic(1'b0, 10);
    run_basic(1'b0, -1);

    // back-to-back with random traffic
    for (int s = 0; s < 120; s++) begin
      for (int c = 0; c < DIM; c++) begin
        bin_v[c] = elem_t'($urandom);
        ain_v[c] = elem_t'($urandom);
      end
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, DIM - 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_ab.md
Name: mem_ab

Overview:
- Combined operand memory for an 8x8 systolic matrix multiplier. Holds matrix A, written one row at a time, and matrix B, loaded one row per enabled cycle.
- Streams both matrices out with diagonal skew, so row/column j lags row/column 0 by j cycles, ready to feed the array's edges.
- Single clock domain. Outputs are registered.

Parameters:
- BITS_AB, 8, signed element width of A and B.
- DIM, 8, matrix dimension (number of rows/columns).
- ROWBITS, $clog2(DIM), derived width of the row index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advances the B-load / stream sequencer.
- WrEn  input  1  writes Ain into A row Arow.
- Arow  input  ROWBITS  A row address for writes.
- Ain  input  DIM x BITS_AB signed  A row data; Ain[c] is element A[Arow][c].
- Bin  input  DIM x BITS_AB signed  B row data; Bin[c] is element B[r][c].
- Aout  output  DIM x BITS_AB signed  skewed A stream, one per array row.
- Bout  output  DIM x BITS_AB signed  skewed B stream, one per array column.

Behaviour:
- Storage: two DIM x DIM arrays of BITS_AB signed registers, A and B.
- Sequencer has two states.
  - LOAD: holds a row counter r (0..DIM-1).
  - STREAM: holds a step counter k (0..3*DIM-3).
- Reset (rst_n=0, asynchronous):
  - A and B storage are cleared to 0.
  - All Aout and Bout are cleared to 0.
  - State goes to LOAD with r=0 and k=0.
- Reset asserted mid-load or mid-stream aborts the operation with no residue.
- A write: on a rising edge with WrEn=1, A[Arow][c] <= Ain[c] for all c.
  - Independent of en and of the sequencer state.
  - A stream read of the same row on the same edge sees the old contents.
- en=0: sequencer, counters, B storage and outputs all hold. Pausing mid-stream freezes Aout/Bout, and the stream resumes on the next en edge.
- LOAD with en=1:
  - B[r][c] <= Bin[c] for all c; r increments.
  - Aout and Bout are driven to 0 on that edge.
  - After the edge that writes r=DIM-1, go to STREAM with k=0.
- STREAM with en=1, on the edge for step k, for every j:
  - Aout[j] <= A[j][k-j] if 0 <= k-j < DIM, else 0.
  - Bout[j] <= B[k-j][j] if 0 <= k-j < DIM, else 0.
  - Bin is ignored in STREAM.
- STREAM length:
  - First element visible right after edge k=0 (latency 1 edge from the first stream-enabled edge).
  - Last non-zero element is Aout/Bout[DIM-1] right after edge k=2*DIM-2.
  - Edges k=2*DIM-1 .. 3*DIM-3 output all zeros, giving drain time for the array.
  - After edge k=3*DIM-3, return to LOAD with r=0. B contents are retained until overwritten.
- Values pass bit-exact; no arithmetic or sign change. Negative extremes (-2^(BITS_AB-1)) are preserved.
- Arow is always in range because DIM is a power of two; non-power-of-two DIM is unsupported.

Test Plan (DIM=8, BITS_AB=8):
1. Reset and readback:
   - Stimulus: pulse rst_n low, then sweep Arow 0..7 with en=0.
   - Required: every Aout[c] and Bout[c] reads 0.
2. Basic stream:
   - Stimulus: load B[i][j]=8i+j+1 over 8 en cycles, then write A[i][j]=-(8i+j+1) via WrEn with en=0, then hold en=1.
   - Edge 0: Bout[0]=1, Aout[0]=-1, all others 0.
   - Edge 7: Bout[0]=57, Bout[7]=8, Aout[7]=-57, Aout[0]=-8.
   - Edge 14: Bout[7]=64, Aout[7]=-64, all others 0.
   - Edges 15..21: all 0.
3. Pause:
   - Stimulus: drop en for 3 cycles after stream edge 4.
   - Required: outputs hold the edge-4 values; edge 5 values appear on the next en edge.
4. Extremes:
   - Stimulus: load B and A entirely with -128 in even columns and 127 in odd columns.
   - Required: values appear unchanged at their skewed slots.
5. Reset mid-stream:
   - Stimulus: assert rst_n at stream edge 10.
   - Required: outputs go to 0 immediately; a subsequent full load/stream reproduces scenario 2 exactly.
6. Back-to-back:
   - Stimulus: after edge 21 keep en=1 with a new Bin.
   - Required: the next 8 edges load new B with outputs 0, then the new stream starts, with Aout taken from the current A.
